// File: rtl/button_pkg.sv
// Shared button definitions: FSM state type, button indices used by the
// display controller, and the counter sizing helper.
package button_pkg;

   typedef enum logic [1:0] {
      IDLE   = 2'd0,
      HELD   = 2'd1,
      REPEAT = 2'd2
   } btn_state_t;

   localparam int BTN_CENTER = 0;
   localparam int BTN_UP     = 1;
   localparam int BTN_LEFT   = 2;
   localparam int BTN_RIGHT  = 3;
   localparam int BTN_DOWN   = 4;

   // Width able to hold (max cycle count - 1); at least one bit.
   function automatic int cnt_width(input int a, input int b, input int c);
      int m;
      m = a;
      if (b > m) m = b;
      if (c > m) m = c;
      return (m <= 2) ? 1 : $clog2(m);
   endfunction

endpackage

// File: rtl/button_channel.sv
// One button: two-flop synchronizer, restartable debounce counter and an
// IDLE/HELD/REPEAT FSM producing registered press/release pulses.
module button_channel
   import button_pkg::*;
#(
   parameter int DEBOUNCE_CYCLES = 1000000,
   parameter int REPEAT_DELAY    = 50000000,
   parameter int REPEAT_PERIOD   = 10000000,
   parameter bit REPEAT_EN       = 1'b0
) (
   input  logic clk,
   input  logic reset,
   input  logic btn,
   output logic stable,
   output logic press_pulse,
   output logic release_pulse,
   output logic repeating
);

   localparam int CW = cnt_width(DEBOUNCE_CYCLES, REPEAT_DELAY, REPEAT_PERIOD);
   localparam logic [CW-1:0] DB_LAST  = CW'(DEBOUNCE_CYCLES - 1);
   localparam logic [CW-1:0] DLY_LAST = CW'(REPEAT_DELAY - 1);
   localparam logic [CW-1:0] PER_LAST = CW'(REPEAT_PERIOD - 1);

   logic          sync1_q, sync1_d;
   logic          sync_q, sync_d;
   logic          stable_q, stable_d;
   logic [CW-1:0] db_cnt_q, db_cnt_d;
   logic [CW-1:0] hold_cnt_q, hold_cnt_d;
   btn_state_t    state_q, state_d;
   logic          press_q, press_d;
   logic          release_q, release_d;
   logic          repeating_q, repeating_d;

   always_comb begin
      sync1_d  = btn;
      sync_d   = sync1_q;
      stable_d = stable_q;
      db_cnt_d = '0;
      if (sync_q != stable_q) begin
         if (db_cnt_q == DB_LAST) stable_d = ~stable_q;
         else                     db_cnt_d = db_cnt_q + CW'(1);
      end

      state_d    = state_q;
      hold_cnt_d = hold_cnt_q;
      press_d    = 1'b0;
      release_d  = 1'b0;
      // Debounced edges take priority, so a release swallows a due repeat.
      if (stable_d && !stable_q) begin
         state_d    = HELD;
         hold_cnt_d = '0;
         press_d    = 1'b1;
      end else if (!stable_d && stable_q) begin
         state_d    = IDLE;
         hold_cnt_d = '0;
         release_d  = 1'b1;
      end else begin
         case (state_q)
            HELD: begin
               if (hold_cnt_q == DLY_LAST) begin
                  hold_cnt_d = '0;
                  if (REPEAT_EN) begin
                     state_d = REPEAT;
                     press_d = 1'b1;
                  end
               end else begin
                  hold_cnt_d = hold_cnt_q + CW'(1);
               end
            end
            REPEAT: begin
               if (hold_cnt_q == PER_LAST) begin
                  hold_cnt_d = '0;
                  press_d    = 1'b1;
               end else begin
                  hold_cnt_d = hold_cnt_q + CW'(1);
               end
            end
            default: hold_cnt_d = '0;
         endcase
      end
      repeating_d = (state_d == REPEAT);
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         sync1_q     <= 1'b0;
         sync_q      <= 1'b0;
         stable_q    <= 1'b0;
         db_cnt_q    <= '0;
         hold_cnt_q  <= '0;
         state_q     <= IDLE;
         press_q     <= 1'b0;
         release_q   <= 1'b0;
         repeating_q <= 1'b0;
      end else begin
         sync1_q     <= sync1_d;
         sync_q      <= sync_d;
         stable_q    <= stable_d;
         db_cnt_q    <= db_cnt_d;
         hold_cnt_q  <= hold_cnt_d;
         state_q     <= state_d;
         press_q     <= press_d;
         release_q   <= release_d;
         repeating_q <= repeating_d;
      end
   end

   assign stable        = stable_q;
   assign press_pulse   = press_q;
   assign release_pulse = release_q;
   assign repeating     = repeating_q;

endmodule

// File: rtl/button_conditioner.sv
// Push-button front end: one independent button_channel per pin, with the
// auto-repeat enable of each channel taken from REPEAT_MASK.
module button_conditioner
   import button_pkg::*;
#(
   parameter int                   N_BUTTONS       = 5,
   parameter int                   DEBOUNCE_CYCLES = 1000000,
   parameter int                   REPEAT_DELAY    = 50000000,
   parameter int                   REPEAT_PERIOD   = 10000000,
   parameter logic [N_BUTTONS-1:0] REPEAT_MASK     = N_BUTTONS'(5'b10010)
) (
   input  logic                 clk,
   input  logic                 reset,
   input  logic [N_BUTTONS-1:0] buttons,
   output logic [N_BUTTONS-1:0] stable,
   output logic [N_BUTTONS-1:0] press_pulse,
   output logic [N_BUTTONS-1:0] release_pulse,
   output logic [N_BUTTONS-1:0] repeating
);

   for (genvar i = 0; i < N_BUTTONS; i++) begin : g_ch
      button_channel #(
         .DEBOUNCE_CYCLES (DEBOUNCE_CYCLES),
         .REPEAT_DELAY    (REPEAT_DELAY),
         .REPEAT_PERIOD   (REPEAT_PERIOD),
         .REPEAT_EN       (REPEAT_MASK[i])
      ) u_ch (
         .clk           (clk),
         .reset         (reset),
         .btn           (buttons[i]),
         .stable        (stable[i]),
         .press_pulse   (press_pulse[i]),
         .release_pulse (release_pulse[i]),
         .repeating     (repeating[i])
      );
   end

endmodule

// File: tb/tb_button_conditioner.sv
// Directed bench for button_conditioner with short debounce/repeat timing.
module tb_button_conditioner;

   logic       clk = 1'b0;
   logic       reset;
   logic [4:0] buttons;
   logic [4:0] stable, press_pulse, release_pulse, repeating;

   int n_cmp = 0;
   int n_err = 0;

   button_conditioner #(
      .N_BUTTONS       (5),
      .DEBOUNCE_CYCLES (4),
      .REPEAT_DELAY    (10),
      .REPEAT_PERIOD   (3),
      .REPEAT_MASK     (5'b10010)
   ) dut (
      .clk           (clk),
      .reset         (reset),
      .buttons       (buttons),
      .stable        (stable),
      .press_pulse   (press_pulse),
      .release_pulse (release_pulse),
      .repeating     (repeating)
   );

   always #5 clk = ~clk;

   // Advance past the next active edge; outputs are settled afterwards.
   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic settle();
      buttons = 5'b0;
      for (int i = 0; i < 12; i++) tick();
   endtask

   task automatic test_reset();
      reset   = 1'b1;
      buttons = 5'b0;
      tick(); tick(); tick();
      n_cmp++; if (stable !== 5'b0)        begin n_err++; $display("FAIL reset_stable got %b want %b", stable, 5'b0); end
      n_cmp++; if (press_pulse !== 5'b0)   begin n_err++; $display("FAIL reset_press got %b want %b", press_pulse, 5'b0); end
      n_cmp++; if (release_pulse !== 5'b0) begin n_err++; $display("FAIL reset_release got %b want %b", release_pulse, 5'b0); end
      n_cmp++; if (repeating !== 5'b0)     begin n_err++; $display("FAIL reset_repeating got %b want %b", repeating, 5'b0); end
      reset = 1'b0;
      tick();
   endtask

   task automatic test_clean_press();
      logic [4:0] ep, es, er;
      buttons = 5'b00001;
      for (int c = 1; c <= 30; c++) begin
         tick();
         ep = (c == 6) ? 5'b00001 : 5'b0;
         es = (c >= 6) ? 5'b00001 : 5'b0;
         n_cmp++; if (press_pulse !== ep) begin n_err++; $display("FAIL clean_press c=%0d got %b want %b", c, press_pulse, ep); end
         n_cmp++; if (stable !== es)      begin n_err++; $display("FAIL clean_stable c=%0d got %b want %b", c, stable, es); end
         n_cmp++; if (repeating !== 5'b0) begin n_err++; $display("FAIL clean_norepeat c=%0d got %b want %b", c, repeating, 5'b0); end
      end
      buttons = 5'b0;
      for (int c = 1; c <= 10; c++) begin
         tick();
         er = (c == 6) ? 5'b00001 : 5'b0;
         n_cmp++; if (release_pulse !== er) begin n_err++; $display("FAIL clean_release c=%0d got %b want %b", c, release_pulse, er); end
         n_cmp++; if (press_pulse !== 5'b0) begin n_err++; $display("FAIL clean_relpress c=%0d got %b want %b", c, press_pulse, 5'b0); end
      end
      settle();
   endtask

   // Bounce on bit 1, then hold into auto-repeat.
   task automatic test_bounce_repeat();
      logic [4:0] ep, erp;
      logic [4:0] pat [4];
      pat[0] = 5'b00010; pat[1] = 5'b0; pat[2] = 5'b00010; pat[3] = 5'b0;
      for (int p = 0; p < 4; p++) begin
         buttons = pat[p];
         for (int c = 0; c < 2; c++) begin
            tick();
            n_cmp++; if (press_pulse !== 5'b0) begin n_err++; $display("FAIL bounce_press p=%0d got %b want %b", p, press_pulse, 5'b0); end
            n_cmp++; if (stable !== 5'b0)      begin n_err++; $display("FAIL bounce_stable p=%0d got %b want %b", p, stable, 5'b0); end
         end
      end
      buttons = 5'b00010;
      for (int c = 1; c <= 6; c++) begin
         tick();
         ep = (c == 6) ? 5'b00010 : 5'b0;
         n_cmp++; if (press_pulse !== ep) begin n_err++; $display("FAIL bounce_final c=%0d got %b want %b", c, press_pulse, ep); end
      end
      for (int c = 1; c <= 25; c++) begin
         tick();
         ep  = (c >= 10 && (c - 10) % 3 == 0) ? 5'b00010 : 5'b0;
         erp = (c >= 10) ? 5'b00010 : 5'b0;
         n_cmp++; if (press_pulse !== ep) begin n_err++; $display("FAIL repeat_press c=%0d got %b want %b", c, press_pulse, ep); end
         n_cmp++; if (repeating !== erp)  begin n_err++; $display("FAIL repeat_flag c=%0d got %b want %b", c, repeating, erp); end
      end
      settle();
      n_cmp++; if (stable !== 5'b0) begin n_err++; $display("FAIL repeat_settle got %b want %b", stable, 5'b0); end
   endtask

   // Release bit 4 timed so its release lands on a cycle a repeat was due.
   task automatic test_release_in_repeat();
      logic [4:0] ep, er, erp;
      buttons = 5'b10000;
      for (int c = 1; c <= 6; c++) tick();
      n_cmp++; if (press_pulse !== 5'b10000) begin n_err++; $display("FAIL rel_first_press got %b want %b", press_pulse, 5'b10000); end
      for (int c = 1; c <= 20; c++) begin
         tick();
         if (c == 10) buttons = 5'b0;
         ep  = (c == 10 || c == 13) ? 5'b10000 : 5'b0;
         er  = (c == 16) ? 5'b10000 : 5'b0;
         erp = (c >= 10 && c < 16) ? 5'b10000 : 5'b0;
         n_cmp++; if (press_pulse !== ep)   begin n_err++; $display("FAIL rel_press c=%0d got %b want %b", c, press_pulse, ep); end
         n_cmp++; if (release_pulse !== er) begin n_err++; $display("FAIL rel_release c=%0d got %b want %b", c, release_pulse, er); end
         n_cmp++; if (repeating !== erp)    begin n_err++; $display("FAIL rel_repeating c=%0d got %b want %b", c, repeating, erp); end
      end
      settle();
   endtask

   task automatic test_simultaneous();
      logic [4:0] ep, er;
      buttons = 5'b01100;
      for (int c = 1; c <= 8; c++) begin
         tick();
         ep = (c == 6) ? 5'b01100 : 5'b0;
         n_cmp++; if (press_pulse !== ep) begin n_err++; $display("FAIL simul_press c=%0d got %b want %b", c, press_pulse, ep); end
      end
      buttons = 5'b0;
      for (int c = 1; c <= 8; c++) begin
         tick();
         er = (c == 6) ? 5'b01100 : 5'b0;
         n_cmp++; if (release_pulse !== er) begin n_err++; $display("FAIL simul_release c=%0d got %b want %b", c, release_pulse, er); end
      end
      settle();
   endtask

   // Reset lands on the edge where a repeat would have been due.
   task automatic test_reset_mid_hold();
      logic [4:0] ep, es;
      buttons = 5'b00010;
      for (int c = 1; c <= 6; c++) tick();
      n_cmp++; if (press_pulse !== 5'b00010) begin n_err++; $display("FAIL rst_first_press got %b want %b", press_pulse, 5'b00010); end
      for (int c = 1; c <= 12; c++) tick();
      n_cmp++; if (repeating !== 5'b00010) begin n_err++; $display("FAIL rst_pre_repeating got %b want %b", repeating, 5'b00010); end
      reset = 1'b1;
      tick();
      reset = 1'b0;
      n_cmp++; if (stable !== 5'b0)        begin n_err++; $display("FAIL rst_stable got %b want %b", stable, 5'b0); end
      n_cmp++; if (press_pulse !== 5'b0)   begin n_err++; $display("FAIL rst_press got %b want %b", press_pulse, 5'b0); end
      n_cmp++; if (release_pulse !== 5'b0) begin n_err++; $display("FAIL rst_release got %b want %b", release_pulse, 5'b0); end
      n_cmp++; if (repeating !== 5'b0)     begin n_err++; $display("FAIL rst_repeating got %b want %b", repeating, 5'b0); end
      for (int c = 1; c <= 8; c++) begin
         tick();
         ep = (c == 6) ? 5'b00010 : 5'b0;
         es = (c >= 6) ? 5'b00010 : 5'b0;
         n_cmp++; if (press_pulse !== ep)   begin n_err++; $display("FAIL rst_repress c=%0d got %b want %b", c, press_pulse, ep); end
         n_cmp++; if (stable !== es)        begin n_err++; $display("FAIL rst_restable c=%0d got %b want %b", c, stable, es); end
         n_cmp++; if (release_pulse !== 5'b0) begin n_err++; $display("FAIL rst_norelease c=%0d got %b want %b", c, release_pulse, 5'b0); end
      end
      settle();
   endtask

   initial begin
      reset   = 1'b1;
      buttons = 5'b0;
      test_reset();
      test_clean_press();
      test_bounce_repeat();
      test_release_in_repeat();
      test_simultaneous();
      test_reset_mid_hold();
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
      $finish;
   end

endmodule

// File: doc/button_conditioner.md
# button_conditioner

Front-end stage for the seven-segment display controller. It synchronizes the raw push-button pins, debounces each button independently, and emits single-cycle press pulses, with optional auto-repeat while a button is held. The display controller consumes `press_pulse` directly as its per-button event vector, so it no longer needs its own debounce logic.

## Interface
- `N_BUTTONS`, 5: number of button channels.
- `DEBOUNCE_CYCLES`, 1000000: consecutive cycles a synchronized level must differ from `stable` before `stable` follows it; legal range ≥ 2.
- `REPEAT_DELAY`, 50000000: hold cycles from the press pulse to the first repeat pulse; legal range ≥ 2.
- `REPEAT_PERIOD`, 10000000: cycles between subsequent repeat pulses; legal range ≥ 2.
- `REPEAT_MASK`, 5'b10010: per-button auto-repeat enable; the default enables up (bit 1) and down (bit 4).
- `clk` input 1: system clock.
- `reset` input 1: synchronous, active-high reset.
- `buttons` input N_BUTTONS: raw asynchronous button pins, 1 = pressed.
- `stable` output N_BUTTONS: debounced level per button.
- `press_pulse` output N_BUTTONS: one-cycle pulse on each debounced press and on each auto-repeat.
- `release_pulse` output N_BUTTONS: one-cycle pulse on each debounced release.
- `repeating` output N_BUTTONS: high while the channel is in REPEAT state.

## Operation
- Per channel: a two-flop synchronizer produces `sync`. It feeds a debounce counter and a 3-state FSM (IDLE, HELD, REPEAT).
- **Debounce**
  - The counter increments every cycle in which `sync != stable`.
  - It clears to 0 in any cycle in which `sync == stable`, so a bounce restarts it.
  - In a mismatch cycle where the counter equals `DEBOUNCE_CYCLES-1`, `stable` toggles at the next edge and the counter clears.
- **FSM transitions**
  - IDLE→HELD on the `stable` 0→1 edge. `press_pulse` asserts in the same cycle that `stable` first reads 1. The hold counter clears.
  - HELD: the hold counter increments while `stable`=1.
  - HELD→REPEAT: only if the `REPEAT_MASK` bit is 1, when the hold counter equals `REPEAT_DELAY-1`. Emit `press_pulse` and clear the counter.
  - REPEAT: emit `press_pulse` each time the counter reaches `REPEAT_PERIOD-1`, then clear the counter.
  - HELD or REPEAT → IDLE on the `stable` 1→0 edge. `release_pulse` asserts in the cycle `stable` first reads 0. Any repeat pulse due in that cycle is suppressed.
  - With the mask bit 0, HELD never advances to REPEAT.
- **Independence and counter behaviour**
  - Channels are fully independent. Simultaneous presses produce multi-bit `press_pulse` words; no arbitration is done here.
  - All counters are sized `$clog2` of the maximum of the three cycle parameters. Counters never wrap, because every compare clears them.
- **Reset**
  - Reset clears synchronizers, counters, `stable`, all pulses and `repeating` to 0, and sets every FSM to IDLE.
  - A button held through reset release re-debounces as a new press: the full `DEBOUNCE_CYCLES` elapse, then one `press_pulse`.

## Timing
- The raw level sampled at edge k appears on `sync` after edge k+2. With no bounce, `stable`, `press_pulse` and `release_pulse` update at edge k+2+`DEBOUNCE_CYCLES`.
- `press_pulse` and `release_pulse` are registered outputs, exactly one cycle wide, and never both high on one channel.
- First repeat pulse: `REPEAT_DELAY` cycles after the press pulse. Later repeat pulses: every `REPEAT_PERIOD` cycles.
- Reset values: all outputs are 0 in the cycle after any edge where `reset`=1. Reset asserted mid-hold or mid-repeat yields no further pulses.

## Structure
- Shared package `button_pkg`:
  - state enum `btn_state_t` (IDLE, HELD, REPEAT);
  - button index constants `BTN_CENTER`=0, `BTN_UP`=1, `BTN_LEFT`=2, `BTN_RIGHT`=3, `BTN_DOWN`=4, also used by the display controller;
  - counter-width function.
- Sub-module: `button_channel`, a single-button synchronizer, debouncer and FSM, instantiated `N_BUTTONS` times in a generate loop. Its `REPEAT_EN` is taken from `REPEAT_MASK[i]`.

## Test plan
All scenarios use `DEBOUNCE_CYCLES`=4, `REPEAT_DELAY`=10, `REPEAT_PERIOD`=3.
- Clean press of bit 0 at edge k, held for 30 cycles → `stable[0]` and a single `press_pulse`=5'b00001 at edge k+6; no repeats (mask bit 0).
- Bounce: bit 1 toggles 1,0,1,0 every 2 cycles, then held high → no pulse during the bounce; exactly one press 6 cycles after the final rise.
- Hold bit 1 for 25 cycles after its press pulse → repeat pulses at +10, +13, +16, +19, +22; `repeating[1]`=1 from +10.
- Release bit 4 while in REPEAT → a single `release_pulse`=5'b10000 6 cycles after the raw fall; no `press_pulse` in or after that cycle; `repeating[4]`=0.
- Bits 2 and 3 pressed on the same edge → `press_pulse`=5'b01100 in one cycle.
- `reset` asserted for 1 cycle during a hold → all outputs 0 next cycle. If the button stays held, one `press_pulse` occurs 6 cycles after reset deasserts.
